// File: rtl/fc_layer_engine.sv
// Fully connected layer controller: streams weights through an external LANES-wide
// multiply-add unit, requantises each neuron to int8 and writes packed result words.
module fc_layer_engine #(
  parameter int unsigned        LANES       = 128,
  parameter int unsigned        IN_CHUNKS   = 2,
  parameter int unsigned        OUT_NEURONS = 128,
  parameter int unsigned        ADDR_W      = 12,
  parameter int unsigned        DOT_W       = 20,
  parameter int unsigned        SHIFT       = 7,
  parameter logic [ADDR_W-1:0]  W_BASE      = 12'h400,
  parameter logic [ADDR_W-1:0]  A_BASE      = 12'h600,
  parameter logic [ADDR_W-1:0]  B_BASE      = 12'h680,
  parameter logic [ADDR_W-1:0]  R_BASE      = 12'h700
) (
  input  logic                 clk,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic                 iRelu,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oOverflow,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [LANES*8-1:0]   mem_rdata,
  input  logic                 mem_rvalid,
  output logic                 res_we,
  output logic [LANES*8-1:0]   res_wdata,
  output logic [LANES*8-1:0]   dot_a,
  output logic [LANES*8-1:0]   dot_b,
  output logic                 dot_valid,
  input  logic [DOT_W-1:0]     dot_result,
  input  logic                 dot_ovf,
  input  logic                 dot_rvalid
);

  localparam int unsigned WW    = LANES * 8;
  localparam int unsigned CHW   = IN_CHUNKS * WW;
  localparam int unsigned ACC_W = DOT_W + $clog2(IN_CHUNKS) + 1;
  localparam int unsigned SUM_W = ACC_W + SHIFT + 8;
  localparam int unsigned CW    = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned NW    = $clog2(OUT_NEURONS + 1);

  localparam logic [CW-1:0] LAST_CHUNK = CW'(IN_CHUNKS - 1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);
  localparam logic [NW-1:0] LAST_N     = NW'(OUT_NEURONS - 1);

  localparam logic signed [SUM_W-1:0] MAX_Q = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] MIN_Q = -SUM_W'(128);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, FETCH_W, DOT, ACC, REQUANT, WRITE, DONE
  } state_t;

  state_t                    state;
  logic                      pend;
  logic [CW-1:0]             chunk;
  logic [LW-1:0]             lane;
  logic [NW-1:0]             n;
  logic [ADDR_W-1:0]         word;
  logic [ADDR_W-1:0]         w_addr;
  logic                      relu_en;
  logic [CHW-1:0]            act_cache;
  logic [WW-1:0]             bias_word;
  logic [WW-1:0]             weight;
  logic signed [DOT_W-1:0]   dot_q;
  logic signed [ACC_W-1:0]   acc;
  logic [WW-1:0]             pack;

  logic signed [7:0]         bias_b;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   scaled;
  logic [7:0]                q;
  logic                      clip;

  // Bias is at output scale, so it is aligned to the accumulator before the floor shift.
  always_comb begin
    bias_b = signed'(bias_word[{lane, 3'b000} +: 8]);
    sum_q  = SUM_W'(acc) + (SUM_W'(bias_b) <<< SHIFT);
    scaled = sum_q >>> SHIFT;
    q      = scaled[7:0];
    clip   = 1'b0;
    if (relu_en && scaled[SUM_W-1]) begin
      q = '0;
    end else if (scaled > MAX_Q) begin
      q    = 8'h7f;
      clip = 1'b1;
    end else if (scaled < MIN_Q) begin
      q    = 8'h80;
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      pend      <= 1'b0;
      chunk     <= '0;
      lane      <= '0;
      n         <= '0;
      word      <= '0;
      w_addr    <= '0;
      relu_en   <= 1'b0;
      act_cache <= '0;
      bias_word <= '0;
      weight    <= '0;
      dot_q     <= '0;
      acc       <= '0;
      pack      <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oOverflow <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      res_we    <= 1'b0;
      res_wdata <= '0;
      dot_a     <= '0;
      dot_b     <= '0;
      dot_valid <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      res_we    <= 1'b0;
      dot_valid <= 1'b0;
      oDone     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iStart) begin
            oBusy     <= 1'b1;
            oOverflow <= 1'b0;
            relu_en   <= iRelu;
            chunk     <= '0;
            lane      <= '0;
            n         <= '0;
            word      <= '0;
            w_addr    <= W_BASE;
            acc       <= '0;
            pack      <= '0;
            pend      <= 1'b0;
            state     <= LOAD_A;
          end
        end
        // Chunks shift in from the top so chunk 0 ends up in the low word.
        LOAD_A: begin
          if (!pend) begin
            mem_rd   <= 1'b1;
            mem_addr <= A_BASE + ADDR_W'(chunk);
            pend     <= 1'b1;
          end else if (mem_rvalid) begin
            pend      <= 1'b0;
            act_cache <= CHW'({mem_rdata, act_cache} >> WW);
            if (chunk == LAST_CHUNK) begin
              chunk <= '0;
              state <= LOAD_B;
            end else begin
              chunk <= chunk + CW'(1);
            end
          end
        end
        LOAD_B: begin
          if (!pend) begin
            mem_rd   <= 1'b1;
            mem_addr <= B_BASE + word;
            pend     <= 1'b1;
          end else if (mem_rvalid) begin
            pend      <= 1'b0;
            bias_word <= mem_rdata;
            state     <= FETCH_W;
          end
        end
        // Weights are fetched in strict n-major order, so a running pointer replaces n*IN_CHUNKS+c.
        FETCH_W: begin
          if (!pend) begin
            mem_rd   <= 1'b1;
            mem_addr <= w_addr;
            pend     <= 1'b1;
          end else if (mem_rvalid) begin
            pend   <= 1'b0;
            weight <= mem_rdata;
            w_addr <= w_addr + ADDR_W'(1);
            state  <= DOT;
          end
        end
        // The cache rotates one word per issue; after IN_CHUNKS issues it is back in order.
        DOT: begin
          if (!pend) begin
            dot_valid <= 1'b1;
            dot_a     <= weight;
            dot_b     <= act_cache[WW-1:0];
            act_cache <= CHW'({act_cache[WW-1:0], act_cache} >> WW);
            pend      <= 1'b1;
          end else if (dot_rvalid) begin
            pend  <= 1'b0;
            dot_q <= signed'(dot_result);
            if (dot_ovf) oOverflow <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc + ACC_W'(dot_q);
          if (chunk == LAST_CHUNK) begin
            chunk <= '0;
            state <= REQUANT;
          end else begin
            chunk <= chunk + CW'(1);
            state <= FETCH_W;
          end
        end
        REQUANT: begin
          pack[{lane, 3'b000} +: 8] <= q;
          if (clip) oOverflow <= 1'b1;
          acc <= '0;
          if (lane == LAST_LANE || n == LAST_N) begin
            state <= WRITE;
          end else begin
            n     <= n + NW'(1);
            lane  <= lane + LW'(1);
            state <= FETCH_W;
          end
        end
        WRITE: begin
          res_we    <= 1'b1;
          mem_addr  <= R_BASE + word;
          res_wdata <= pack;
          pack      <= '0;
          if (n == LAST_N) begin
            state <= DONE;
          end else begin
            n     <= n + NW'(1);
            lane  <= '0;
            word  <= word + ADDR_W'(1);
            state <= LOAD_B;
          end
        end
        DONE: begin
          oDone <= 1'b1;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
